// File: rtl/alu_flag_stage_pkg.sv
// Shared ALU definitions: condition codes, NZCV bit positions, default widths.
package alu_pkg;

  localparam int unsigned WIDTH_DEFAULT = 64;
  localparam int unsigned RW_DEFAULT    = 5;

  // Bit positions inside the 4-bit NZCV vector.
  localparam int unsigned N_BIT = 3;
  localparam int unsigned Z_BIT = 2;
  localparam int unsigned C_BIT = 1;
  localparam int unsigned V_BIT = 0;

  typedef logic [3:0] nzcv_t;

  // ARM condition codes for B.cond.
  typedef enum logic [3:0] {
    COND_EQ = 4'b0000,
    COND_NE = 4'b0001,
    COND_HS = 4'b0010,
    COND_LO = 4'b0011,
    COND_MI = 4'b0100,
    COND_PL = 4'b0101,
    COND_VS = 4'b0110,
    COND_VC = 4'b0111,
    COND_HI = 4'b1000,
    COND_LS = 4'b1001,
    COND_GE = 4'b1010,
    COND_LT = 4'b1011,
    COND_GT = 4'b1100,
    COND_LE = 4'b1101,
    COND_AL = 4'b1110,
    COND_NV = 4'b1111
  } cond_t;

  // Assemble the NZCV vector from individual ALU flag bits.
  function automatic nzcv_t pack_nzcv(input logic n, input logic z,
                                      input logic c, input logic v);
    nzcv_t f;
    f        = '0;
    f[N_BIT] = n;
    f[Z_BIT] = z;
    f[C_BIT] = c;
    f[V_BIT] = v;
    return f;
  endfunction

endpackage

// File: rtl/alu_flag_stage_cond_eval.sv
// Combinational ARM condition-code evaluator against an NZCV vector.
module cond_eval
  import alu_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  output logic       taken
);

  logic  n, z, c, v;
  cond_t cc;

  assign n  = nzcv[N_BIT];
  assign z  = nzcv[Z_BIT];
  assign c  = nzcv[C_BIT];
  assign v  = nzcv[V_BIT];
  assign cc = cond_t'(cond);

  // Decode the condition code into a taken decision.
  always_comb begin
    taken = 1'b0;
    case (cc)
      COND_EQ: taken = z;
      COND_NE: taken = !z;
      COND_HS: taken = c;
      COND_LO: taken = !c;
      COND_MI: taken = n;
      COND_PL: taken = !n;
      COND_VS: taken = v;
      COND_VC: taken = !v;
      COND_HI: taken = c && !z;
      COND_LS: taken = !c || z;
      COND_GE: taken = (n == v);
      COND_LT: taken = (n != v);
      COND_GT: taken = !z && (n == v);
      COND_LE: taken = z || (n != v);
      COND_AL: taken = 1'b1;
      COND_NV: taken = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_flag_stage.sv
// Execute-stage output register: captures ALU result and controls, owns the
// architectural NZCV register, resolves CBZ / B.cond, and hands off to the
// memory stage over valid/ready with stall and flush.
module alu_flag_stage
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT,
  parameter int unsigned RW    = RW_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_n,
  input  logic             alu_z,
  input  logic             alu_c,
  input  logic             alu_v,
  input  logic             set_flags,
  input  logic             is_cbz,
  input  logic             is_bcond,
  input  logic [3:0]       cond,
  input  logic [WIDTH-1:0] store_data,
  input  logic [RW-1:0]    rd,
  input  logic             reg_write,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [WIDTH-1:0] out_store_data,
  output logic [RW-1:0]    out_rd,
  output logic             out_reg_write,
  output logic             out_mem_read,
  output logic             out_mem_write,
  output logic             out_branch_taken,
  output logic [3:0]       flags_q
);

  logic             out_valid_q,        out_valid_d;
  logic [WIDTH-1:0] out_result_q,       out_result_d;
  logic [WIDTH-1:0] out_store_data_q,   out_store_data_d;
  logic [RW-1:0]    out_rd_q,           out_rd_d;
  logic             out_reg_write_q,    out_reg_write_d;
  logic             out_mem_read_q,     out_mem_read_d;
  logic             out_mem_write_q,    out_mem_write_d;
  logic             out_branch_taken_q, out_branch_taken_d;
  logic [3:0]       flags_d;

  logic accept;
  logic bcond_taken;

  // B.cond is judged against the flags already committed, never this
  // instruction's own flag result.
  cond_eval u_cond_eval (
    .cond  (cond),
    .nzcv  (flags_q),
    .taken (bcond_taken)
  );

  // Handshake: space is available when empty or when the held entry leaves.
  always_comb begin
    in_ready = !out_valid_q || out_ready;
    accept   = in_valid && in_ready && !flush;
  end

  // Next-state: flush beats accept beats drain; otherwise everything holds.
  always_comb begin
    out_valid_d        = out_valid_q;
    out_result_d       = out_result_q;
    out_store_data_d   = out_store_data_q;
    out_rd_d           = out_rd_q;
    out_reg_write_d    = out_reg_write_q;
    out_mem_read_d     = out_mem_read_q;
    out_mem_write_d    = out_mem_write_q;
    out_branch_taken_d = out_branch_taken_q;
    flags_d            = flags_q;

    if (flush) begin
      // Side-effect controls are zeroed so a squashed entry can never write.
      out_valid_d     = 1'b0;
      out_reg_write_d = 1'b0;
      out_mem_read_d  = 1'b0;
      out_mem_write_d = 1'b0;
    end else if (accept) begin
      out_valid_d      = 1'b1;
      out_result_d     = alu_result;
      out_store_data_d = store_data;
      out_rd_d         = rd;
      out_reg_write_d  = reg_write;
      out_mem_read_d   = mem_read;
      out_mem_write_d  = mem_write;
      if (is_cbz) begin
        out_branch_taken_d = alu_z;
      end else if (is_bcond) begin
        out_branch_taken_d = bcond_taken;
      end else begin
        out_branch_taken_d = 1'b0;
      end
      if (set_flags) begin
        flags_d = pack_nzcv(alu_n, alu_z, alu_c, alu_v);
      end
    end else if (in_ready) begin
      // Held entry consumed (or stage already empty) with nothing new.
      out_valid_d = 1'b0;
    end
  end

  // State register with asynchronous active-high reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q        <= 1'b0;
      out_result_q       <= '0;
      out_store_data_q   <= '0;
      out_rd_q           <= '0;
      out_reg_write_q    <= 1'b0;
      out_mem_read_q     <= 1'b0;
      out_mem_write_q    <= 1'b0;
      out_branch_taken_q <= 1'b0;
      flags_q            <= '0;
    end else begin
      out_valid_q        <= out_valid_d;
      out_result_q       <= out_result_d;
      out_store_data_q   <= out_store_data_d;
      out_rd_q           <= out_rd_d;
      out_reg_write_q    <= out_reg_write_d;
      out_mem_read_q     <= out_mem_read_d;
      out_mem_write_q    <= out_mem_write_d;
      out_branch_taken_q <= out_branch_taken_d;
      flags_q            <= flags_d;
    end
  end

  // Registered outputs.
  always_comb begin
    out_valid        = out_valid_q;
    out_result       = out_result_q;
    out_store_data   = out_store_data_q;
    out_rd           = out_rd_q;
    out_reg_write    = out_reg_write_q;
    out_mem_read     = out_mem_read_q;
    out_mem_write    = out_mem_write_q;
    out_branch_taken = out_branch_taken_q;
  end

endmodule

// File: tb/tb_alu_flag_stage.sv
// Bench for alu_flag_stage: directed vector table, hand-written stall and
// reset sequences, then randomized traffic against a behavioural model.
module tb_alu_flag_stage;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] alu_result;
  logic        alu_n, alu_z, alu_c, alu_v;
  logic        set_flags;
  logic        is_cbz;
  logic        is_bcond;
  logic [3:0]  cond;
  logic [63:0] store_data;
  logic [4:0]  rd;
  logic        reg_write, mem_read, mem_write;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_result;
  logic [63:0] out_store_data;
  logic [4:0]  out_rd;
  logic        out_reg_write, out_mem_read, out_mem_write;
  logic        out_branch_taken;
  logic [3:0]  flags_q;

  alu_flag_stage #(.WIDTH(64), .RW(5)) dut (
    .clk              (clk),
    .reset            (reset),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .alu_result       (alu_result),
    .alu_n            (alu_n),
    .alu_z            (alu_z),
    .alu_c            (alu_c),
    .alu_v            (alu_v),
    .set_flags        (set_flags),
    .is_cbz           (is_cbz),
    .is_bcond         (is_bcond),
    .cond             (cond),
    .store_data       (store_data),
    .rd               (rd),
    .reg_write        (reg_write),
    .mem_read         (mem_read),
    .mem_write        (mem_write),
    .flush            (flush),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_result       (out_result),
    .out_store_data   (out_store_data),
    .out_rd           (out_rd),
    .out_reg_write    (out_reg_write),
    .out_mem_read     (out_mem_read),
    .out_mem_write    (out_mem_write),
    .out_branch_taken (out_branch_taken),
    .flags_q          (flags_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // ARM-style condition: evaluate the even base code, invert for odd codes
  // except 1111 which is always true.
  function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v, r;
    n = f[3]; z = f[2]; cf = f[1]; v = f[0];
    case (c[3:1])
      3'd0:    r = z;
      3'd1:    r = cf;
      3'd2:    r = n;
      3'd3:    r = v;
      3'd4:    r = cf && !z;
      3'd5:    r = (n == v);
      3'd6:    r = (n == v) && !z;
      default: r = 1'b1;
    endcase
    if (c[0] && c != 4'hF) r = !r;
    return r;
  endfunction

  task automatic idle_inputs();
    in_valid = 0; out_ready = 1; flush = 0; set_flags = 0;
    {alu_n, alu_z, alu_c, alu_v} = 4'b0000;
    is_cbz = 0; is_bcond = 0; cond = 4'h0;
    alu_result = '0; store_data = '0; rd = '0;
    reg_write = 0; mem_read = 0; mem_write = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        iv, ordy, fl, sf;
    logic [3:0]  nzcv;
    logic        cbz, bc;
    logic [3:0]  cnd;
    logic [63:0] res;
    logic        mw;
    logic        e_valid;
    logic [3:0]  e_flags;
    logic        chk;      // compare taken/result
    logic        e_taken;
    logic        e_mw;
  } vec_t;

  function automatic vec_t mk(input logic iv, input logic ordy, input logic fl, input logic sf,
                              input logic [3:0] nzcv, input logic cbz, input logic bc,
                              input logic [3:0] cnd, input logic [63:0] res, input logic mw,
                              input logic e_valid, input logic [3:0] e_flags, input logic chk,
                              input logic e_taken, input logic e_mw);
    vec_t t;
    t.iv = iv; t.ordy = ordy; t.fl = fl; t.sf = sf; t.nzcv = nzcv;
    t.cbz = cbz; t.bc = bc; t.cnd = cnd; t.res = res; t.mw = mw;
    t.e_valid = e_valid; t.e_flags = e_flags; t.chk = chk;
    t.e_taken = e_taken; t.e_mw = e_mw;
    return t;
  endfunction

  vec_t vecs[12];

  // Behavioural model state
  logic        m_valid, m_ctl_known, m_rw, m_mr, m_mw, m_br;
  logic [63:0] m_res, m_sd;
  logic [4:0]  m_rd;
  logic [3:0]  m_flags;

  initial begin
    idle_inputs();
    reset = 1;
    #12;
    check("reset_out_valid", out_valid, 0);
    check("reset_flags", flags_q, 0);
    check("reset_result", out_result, 0);
    check("reset_controls", {out_reg_write, out_mem_read, out_mem_write, out_branch_taken}, 0);
    @(negedge clk);
    reset = 0;
    #1;
    check("idle_in_ready", in_ready, 1);

    // ---------------- directed table ----------------
    //           iv or fl sf nzcv    cbz bc cnd     res    mw  ev ef     chk tk mw
    vecs[0]  = mk(1, 1, 0, 1, 4'b0110, 0, 0, 4'h0, 64'h0,  0,  1, 4'b0110, 1, 0, 0);
    vecs[1]  = mk(1, 1, 0, 0, 4'b0000, 0, 1, 4'h0, 64'h10, 0,  1, 4'b0110, 1, 1, 0);
    vecs[2]  = mk(1, 1, 0, 0, 4'b0000, 0, 1, 4'h1, 64'h11, 0,  1, 4'b0110, 1, 0, 0);
    vecs[3]  = mk(1, 1, 0, 1, 4'b0000, 0, 0, 4'h0, 64'h12, 0,  1, 4'b0000, 1, 0, 0);
    vecs[4]  = mk(1, 1, 0, 1, 4'b0100, 0, 1, 4'h0, 64'h13, 0,  1, 4'b0100, 1, 0, 0);
    vecs[5]  = mk(1, 1, 1, 1, 4'b1111, 0, 0, 4'h0, 64'h14, 1,  0, 4'b0100, 0, 0, 0);
    vecs[6]  = mk(1, 1, 0, 0, 4'b0000, 1, 0, 4'h0, 64'h15, 1,  1, 4'b0100, 1, 0, 1);
    vecs[7]  = mk(1, 1, 0, 0, 4'b0100, 1, 1, 4'h1, 64'h16, 0,  1, 4'b0100, 1, 1, 0);
    vecs[8]  = mk(1, 1, 0, 1, 4'b1001, 0, 0, 4'h0, 64'h17, 0,  1, 4'b1001, 1, 0, 0);
    vecs[9]  = mk(1, 1, 0, 0, 4'b0000, 0, 1, 4'hA, 64'h18, 0,  1, 4'b1001, 1, 1, 0);
    vecs[10] = mk(1, 1, 0, 0, 4'b0000, 0, 1, 4'hB, 64'h19, 0,  1, 4'b1001, 1, 0, 0);
    vecs[11] = mk(0, 1, 0, 0, 4'b0000, 0, 0, 4'h0, 64'h1A, 0,  0, 4'b1001, 0, 0, 0);

    for (int i = 0; i < 12; i++) begin
      in_valid = vecs[i].iv; out_ready = vecs[i].ordy; flush = vecs[i].fl;
      set_flags = vecs[i].sf; {alu_n, alu_z, alu_c, alu_v} = vecs[i].nzcv;
      is_cbz = vecs[i].cbz; is_bcond = vecs[i].bc; cond = vecs[i].cnd;
      alu_result = vecs[i].res; mem_write = vecs[i].mw;
      tick();
      check($sformatf("vec%0d_valid", i), out_valid, vecs[i].e_valid);
      check($sformatf("vec%0d_flags", i), flags_q, vecs[i].e_flags);
      if (vecs[i].chk) begin
        check($sformatf("vec%0d_taken", i), out_branch_taken, vecs[i].e_taken);
        check($sformatf("vec%0d_result", i), out_result, vecs[i].res);
      end
      if (vecs[i].e_valid || vecs[i].fl)
        check($sformatf("vec%0d_mem_write", i), out_mem_write, vecs[i].e_mw);
    end

    // ---------------- stall ----------------
    idle_inputs();
    in_valid = 1; alu_result = 64'h1111;
    tick();
    check("stall_pre_result", out_result, 64'h1111);
    out_ready = 0; alu_result = 64'hDEAD; set_flags = 1;
    {alu_n, alu_z, alu_c, alu_v} = 4'b0110;
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("stall%0d_in_ready", k), in_ready, 0);
      tick();
      check($sformatf("stall%0d_valid", k), out_valid, 1);
      check($sformatf("stall%0d_result", k), out_result, 64'h1111);
      check($sformatf("stall%0d_flags", k), flags_q, 4'b1001);
    end
    out_ready = 1;
    #1;
    check("unstall_in_ready", in_ready, 1);
    tick();
    check("unstall_result", out_result, 64'hDEAD);
    check("unstall_flags", flags_q, 4'b0110);

    // ---------------- reset mid-hold ----------------
    out_ready = 0; set_flags = 0;
    tick();
    check("hold_valid", out_valid, 1);
    #2;
    reset = 1;
    #1;
    check("async_reset_valid", out_valid, 0);
    check("async_reset_flags", flags_q, 0);
    check("async_reset_result", out_result, 0);
    @(negedge clk);
    reset = 0;
    #1;
    check("post_reset_in_ready", in_ready, 1);

    // ---------------- randomized against model ----------------
    m_valid = 0; m_ctl_known = 1; m_rw = 0; m_mr = 0; m_mw = 0; m_br = 0;
    m_res = '0; m_sd = '0; m_rd = '0; m_flags = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      logic m_in_ready;
      in_valid   = ($urandom_range(0, 3) != 0);
      out_ready  = ($urandom_range(0, 3) != 0);
      flush      = ($urandom_range(0, 9) == 0);
      set_flags  = $urandom_range(0, 1);
      {alu_n, alu_z, alu_c, alu_v} = 4'($urandom);
      is_cbz     = ($urandom_range(0, 4) == 0);
      is_bcond   = ($urandom_range(0, 1) == 1);
      cond       = 4'($urandom);
      alu_result = {$urandom, $urandom};
      store_data = {$urandom, $urandom};
      rd         = 5'($urandom);
      reg_write  = $urandom_range(0, 1);
      mem_read   = $urandom_range(0, 1);
      mem_write  = $urandom_range(0, 1);
      m_in_ready = !m_valid || out_ready;
      #1;
      check("rnd_in_ready", in_ready, m_in_ready);
      tick();
      if (flush) begin
        m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_ctl_known = 1;
      end else if (in_valid && m_in_ready) begin
        m_valid = 1; m_ctl_known = 1;
        m_res = alu_result; m_sd = store_data; m_rd = rd;
        m_rw = reg_write; m_mr = mem_read; m_mw = mem_write;
        m_br = is_cbz ? alu_z : (is_bcond ? ref_cond(cond, m_flags) : 1'b0);
        if (set_flags) m_flags = {alu_n, alu_z, alu_c, alu_v};
      end else if (m_in_ready) begin
        m_valid = 0; m_ctl_known = 0;
      end
      check("rnd_valid", out_valid, m_valid);
      check("rnd_flags", flags_q, m_flags);
      if (m_valid) begin
        check("rnd_result", out_result, m_res);
        check("rnd_store_data", out_store_data, m_sd);
        check("rnd_rd", out_rd, m_rd);
        check("rnd_taken", out_branch_taken, m_br);
      end
      if (m_ctl_known)
        check("rnd_controls", {out_reg_write, out_mem_read, out_mem_write}, {m_rw, m_mr, m_mw});
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
